// File: rtl/funcmod_dac_fifo_if.sv
// Register write bus into the DAC FIFO block.
// The host drives it through the master modport and the block receives it through the slave modport.
interface funcmod_dac_fifo_if;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_dat;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_dat
    );

    modport slave (
        input wr_en,
        input wr_addr,
        input wr_dat
    );
endinterface

// File: rtl/funcmod_dac_fifo.sv
// Register-fed sample FIFO that plays words out to a DAC at a programmable period.
// Each played sample is accompanied by a stretchable sample-clock strobe.
module funcmod_dac_fifo #(
    parameter int unsigned ADDR  = 0,
    parameter int unsigned W_AIO = 16,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned W_DIV = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    funcmod_dac_fifo_if.slave        bus,
    output logic                     smp,
    output logic [W_AIO-1:0]         dat,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    output logic                     udf
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [7:0]  A_DATA = 8'(ADDR);
    localparam logic [7:0]  A_DIV  = 8'(ADDR + 1);
    localparam logic [7:0]  A_CTRL = 8'(ADDR + 2);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [W_AIO-1:0] mem [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic [W_AIO-1:0] dat_q, dat_d;
    logic [W_DIV-1:0] div_q, div_d;
    logic [W_DIV-1:0] cnt_q, cnt_d;
    logic [3:0]       sw_q, sw_d;
    logic [4:0]       scnt_q, scnt_d;
    logic             run_q, run_d;
    logic             fire_q, fire_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic wr_data, wr_div, wr_ctrl;
    logic flush, clr_flags;
    logic tick, pop, push_ok, drop;
    logic unused_wr;

    assign wr_data   = bus.wr_en && (bus.wr_addr == A_DATA);
    assign wr_div    = bus.wr_en && (bus.wr_addr == A_DIV);
    assign wr_ctrl   = bus.wr_en && (bus.wr_addr == A_CTRL);
    assign flush     = wr_ctrl && bus.wr_dat[1];
    assign clr_flags = wr_ctrl && bus.wr_dat[2];
    assign unused_wr = ^bus.wr_dat;

    assign tick    = run_q && (cnt_q == '0);
    assign pop     = tick && (level_q != '0);
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok = wr_data && ((level_q != FULL_LVL) || pop);
    assign drop    = wr_data && (level_q == FULL_LVL) && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        dat_d    = dat_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        sw_d     = sw_q;
        scnt_d   = scnt_q;
        run_d    = run_q;
        fire_d   = pop;
        ovf_d    = ovf_q;
        udf_d    = udf_q;

        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            dat_d    = mem[rd_ptr_q];
        end
        unique case ({push_ok, pop})
            2'b10:   level_d = level_q + (AW + 1)'(1);
            2'b01:   level_d = level_q - (AW + 1)'(1);
            default: level_d = level_q;
        endcase
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end

        if (wr_div) div_d = bus.wr_dat[W_DIV-1:0];
        if (wr_ctrl) begin
            run_d = bus.wr_dat[0];
            sw_d  = bus.wr_dat[7:4];
        end

        if (!run_q)      cnt_d = '0;
        else if (tick)   cnt_d = div_q;
        else             cnt_d = cnt_q - W_DIV'(1);

        // Reloading on every fire keeps smp high across back-to-back samples.
        if (fire_q)              scnt_d = {1'b0, sw_q} + 5'd1;
        else if (scnt_q != '0)   scnt_d = scnt_q - 5'd1;

        // Clear first so a coincident set wins.
        if (clr_flags) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (drop)                       ovf_d = 1'b1;
        if (tick && (level_q == '0))    udf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            dat_q    <= '0;
            div_q    <= '0;
            cnt_q    <= '0;
            sw_q     <= 4'd1;
            scnt_q   <= '0;
            run_q    <= 1'b0;
            fire_q   <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            dat_q    <= dat_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            sw_q     <= sw_d;
            scnt_q   <= scnt_d;
            run_q    <= run_d;
            fire_q   <= fire_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_ok && !flush) mem[wr_ptr_q] <= bus.wr_dat[W_AIO-1:0];
    end

    assign smp   = (scnt_q != '0);
    assign dat   = dat_q;
    assign level = level_q;
    assign ovf   = ovf_q;
    assign udf   = udf_q;

endmodule

// File: tb/tb_funcmod_dac_fifo.sv
// Directed bench for funcmod_dac_fifo: inputs change and outputs are sampled on the falling edge.
module tb_funcmod_dac_fifo;
    logic        clk = 1'b0;
    logic        rst;
    logic        smp;
    logic [15:0] dat;
    logic [4:0]  level;
    logic        ovf;
    logic        udf;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    funcmod_dac_fifo_if bus ();

    funcmod_dac_fifo #(
        .ADDR  (0),
        .W_AIO (16),
        .DEPTH (16),
        .W_DIV (16)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .smp   (smp),
        .dat   (dat),
        .level (level),
        .ovf   (ovf),
        .udf   (udf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called on a falling edge; returns one falling edge later with the write applied.
    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_dat  = d;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [15:0] prev_dat;
        logic        prev_smp;
        int          changes;
        int          highs;
        int          rises;

        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_dat  = '0;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);

        check("rst_dat", 32'(dat), 32'h0);
        check("rst_smp", 32'(smp), 32'h0);
        check("rst_level", 32'(level), 32'h0);
        check("rst_ovf", 32'(ovf), 32'h0);
        check("rst_udf", 32'(udf), 32'h0);

        wr(8'h03, 32'h55);
        wr(8'hFF, 32'h77);
        check("bad_addr_level", 32'(level), 32'h0);

        // Single sample at div=0, then underflow on the next tick.
        wr(8'h00, 32'h1234);
        check("s1_level_push", 32'(level), 32'h1);
        wr(8'h01, 32'h0);
        wr(8'h02, 32'h11);
        check("s1_dat_c1", 32'(dat), 32'h0);
        check("s1_level_c1", 32'(level), 32'h1);
        idle(1);
        check("s1_dat_c2", 32'(dat), 32'h1234);
        check("s1_level_c2", 32'(level), 32'h0);
        check("s1_smp_c2", 32'(smp), 32'h0);
        idle(1);
        check("s1_smp_c3", 32'(smp), 32'h1);
        check("s1_udf_c3", 32'(udf), 32'h1);
        idle(1);
        check("s1_smp_c4", 32'(smp), 32'h1);
        idle(1);
        check("s1_smp_c5", 32'(smp), 32'h0);
        // Still running here, so the empty tick sets udf while the write clears it.
        wr(8'h02, 32'h14);
        check("set_wins_udf", 32'(udf), 32'h1);
        wr(8'h02, 32'h14);
        check("clr_udf", 32'(udf), 32'h0);

        // Overflow with run off, then clear flags.
        for (int i = 0; i < 17; i++) wr(8'h00, 32'h100 + 32'(i));
        check("ovf_level", 32'(level), 32'd16);
        check("ovf_set", 32'(ovf), 32'h1);
        wr(8'h02, 32'h14);
        check("ovf_clr", 32'(ovf), 32'h0);
        check("ovf_clr_level", 32'(level), 32'd16);

        // Full FIFO streaming at div=0 with a push every cycle.
        wr(8'h02, 32'h11);
        for (int k = 0; k < 20; k++) begin
            wr(8'h00, 32'h200 + 32'(k));
            check("stream_level", 32'(level), 32'd16);
            check("stream_ovf", 32'(ovf), 32'h0);
            check("stream_dat", 32'(dat),
                  (k < 16) ? 32'h100 + 32'(k) : 32'h200 + 32'(k - 16));
            if (k >= 1) check("stream_smp", 32'(smp), 32'h1);
        end
        wr(8'h02, 32'h12);
        check("flush_level", 32'(level), 32'h0);
        wr(8'h02, 32'h14);

        // div=9: four samples ten clocks apart, then underflow.
        wr(8'h01, 32'd9);
        for (int i = 0; i < 4; i++) wr(8'h00, 32'hA0 + 32'(i));
        check("p10_level", 32'(level), 32'h4);
        wr(8'h02, 32'h11);
        changes  = 0;
        highs    = 0;
        rises    = 0;
        prev_dat = dat;
        prev_smp = smp;
        for (int c = 1; c <= 45; c++) begin
            if (c == 2)  check("p10_dat0", 32'(dat), 32'hA0);
            if (c == 11) check("p10_dat_hold", 32'(dat), 32'hA0);
            if (c == 12) check("p10_dat1", 32'(dat), 32'hA1);
            if (c == 22) check("p10_dat2", 32'(dat), 32'hA2);
            if (c == 32) check("p10_dat3", 32'(dat), 32'hA3);
            if (c == 41) check("p10_udf_before", 32'(udf), 32'h0);
            if (c == 42) check("p10_udf_after", 32'(udf), 32'h1);
            if (c >= 3 && dat !== prev_dat) changes++;
            if (smp) highs++;
            if (smp && !prev_smp) rises++;
            prev_dat = dat;
            prev_smp = smp;
            idle(1);
        end
        check("p10_changes", 32'(changes), 32'd3);
        check("p10_smp_highs", 32'(highs), 32'd8);
        check("p10_smp_pulses", 32'(rises), 32'd4);
        wr(8'h02, 32'h14);
        wr(8'h02, 32'h14);
        check("p10_udf_clr", 32'(udf), 32'h0);

        // sw=3, div=2: strobe restarts and stays high while samples flow.
        wr(8'h01, 32'd2);
        for (int i = 0; i < 4; i++) wr(8'h00, 32'hB0 + 32'(i));
        wr(8'h02, 32'h31);
        for (int c = 1; c <= 17; c++) begin
            check("cont_smp", 32'(smp), (c >= 3 && c <= 15) ? 32'h1 : 32'h0);
            if (c == 2)  check("cont_dat0", 32'(dat), 32'hB0);
            if (c == 4)  check("cont_dat_hold", 32'(dat), 32'hB0);
            if (c == 5)  check("cont_dat1", 32'(dat), 32'hB1);
            if (c == 8)  check("cont_dat2", 32'(dat), 32'hB2);
            if (c == 11) check("cont_dat3", 32'(dat), 32'hB3);
            idle(1);
        end
        wr(8'h02, 32'h14);
        wr(8'h02, 32'h14);

        // Reset in the middle of a strobe.
        wr(8'h01, 32'd9);
        for (int i = 0; i < 6; i++) wr(8'h00, 32'hC0 + 32'(i));
        wr(8'h02, 32'h11);
        idle(2);
        check("mid_smp", 32'(smp), 32'h1);
        check("mid_level", 32'(level), 32'h5);
        rst = 1'b1;
        idle(1);
        check("mrst_smp", 32'(smp), 32'h0);
        check("mrst_level", 32'(level), 32'h0);
        check("mrst_dat", 32'(dat), 32'h0);
        check("mrst_ovf", 32'(ovf), 32'h0);
        check("mrst_udf", 32'(udf), 32'h0);
        wr(8'h00, 32'hDEAD);
        check("mrst_wr_ignored", 32'(level), 32'h0);
        rst = 1'b0;
        highs = 0;
        for (int c = 0; c < 25; c++) begin
            if (smp) highs++;
            idle(1);
        end
        check("post_rst_no_smp", 32'(highs), 32'h0);
        wr(8'h00, 32'h1);
        idle(12);
        check("post_rst_run_off", 32'(level), 32'h1);
        check("post_rst_dat", 32'(dat), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
